plot_arbiter: RTL and testbench

PLOT_ARBITER -- requirements
Module: plot_arbiter

---
 rtl/plot_arbiter_if.sv | 57 +++++
 rtl/plot_arbiter.sv | 174 +++++++++++++++++
 tb/tb_plot_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/plot_arbiter_if.sv
// -----------------------------------------------------------------------------
// plot_arbiter_if
// Bundles the two requester ports and the VGA write port of plot_arbiter.
//
// Signals (names follow the external pin list of the arbiter):
//   req0/req1        requester asks for the VGA write port (held for a burst)
//   x0/x1 (8)        requester pixel x coordinate
//   y0/y1 (7)        requester pixel y coordinate
//   colour0/1 (3)    requester pixel colour
//   plot0/plot1      requester pixel valid, honoured only while granted
//   gnt0/gnt1        requester currently owns the write port
//   vga_x/vga_y/vga_colour/vga_plot   registered write port to the VGA adapter
//   pix_count (15)   pixels written since reset (saturating)
//   clip_count (8)   off-screen pixels dropped since reset (saturating)
//
// Modports:
//   master : requester / environment side
//   slave  : arbiter side
// -----------------------------------------------------------------------------
interface plot_arbiter_if;
   logic        req0;
   logic [7:0]  x0;
   logic [6:0]  y0;
   logic [2:0]  colour0;
   logic        plot0;
   logic        gnt0;

   logic        req1;
   logic [7:0]  x1;
   logic [6:0]  y1;
   logic [2:0]  colour1;
   logic        plot1;
   logic        gnt1;

   logic [7:0]  vga_x;
   logic [6:0]  vga_y;
   logic [2:0]  vga_colour;
   logic        vga_plot;
   logic [14:0] pix_count;
   logic [7:0]  clip_count;

   modport master (
      output req0, x0, y0, colour0, plot0,
      output req1, x1, y1, colour1, plot1,
      input  gnt0, gnt1,
      input  vga_x, vga_y, vga_colour, vga_plot,
      input  pix_count, clip_count
   );

   modport slave (
      input  req0, x0, y0, colour0, plot0,
      input  req1, x1, y1, colour1, plot1,
      output gnt0, gnt1,
      output vga_x, vga_y, vga_colour, vga_plot,
      output pix_count, clip_count
   );
endinterface

// File: rtl/plot_arbiter.sv
// -----------------------------------------------------------------------------
// plot_arbiter
// Two-requester round-robin arbiter for a single VGA adapter write port.
// A requester holds reqk high for a whole burst; once granted it keeps the port
// until it drops reqk (no preemption). Ownership always passes through IDLE,
// so there is at least one idle cycle between owners. Ties in IDLE go to the
// requester that was not served last (requester 0 wins the first tie).
//
// Accepted pixels (granted and plotk=1) are forwarded to the VGA port with one
// cycle of latency. Off-screen pixels (x>=160 or y>=120) are dropped and
// counted in clip_count; on-screen pixels pulse vga_plot and are counted in
// pix_count. Both counters saturate.
//
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : plot_arbiter_if.slave (requesters, grants, VGA port, counters)
// -----------------------------------------------------------------------------
module plot_arbiter (
   input  logic          clk,
   input  logic          rst,
   plot_arbiter_if.slave bus
);

   localparam logic [7:0] X_LIMIT = 8'd160;
   localparam logic [6:0] Y_LIMIT = 7'd120;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic        last_q, last_d;   // requester served most recently
   logic        gnt0_q, gnt1_q;

   logic [7:0]  vga_x_q, vga_x_d;
   logic [6:0]  vga_y_q, vga_y_d;
   logic [2:0]  vga_colour_q, vga_colour_d;
   logic        vga_plot_q, vga_plot_d;
   logic [14:0] pix_count_q, pix_count_d;
   logic [7:0]  clip_count_q, clip_count_d;

   logic        accept;
   logic        on_screen;
   logic [7:0]  sel_x;
   logic [6:0]  sel_y;
   logic [2:0]  sel_colour;

   function automatic logic [14:0] sat_inc_pix(input logic [14:0] v);
      return (v == 15'h7FFF) ? v : v + 15'd1;
   endfunction

   function automatic logic [7:0] sat_inc_clip(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // ------------------------------------------------------------------
   // Arbitration FSM: next state and last-served bookkeeping
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      case (state_q)
         IDLE: begin
            if (bus.req0 && bus.req1) begin
               // Round-robin tie break: favour whoever was not served last.
               state_d = last_q ? OWN0 : OWN1;
            end else if (bus.req0) begin
               state_d = OWN0;
            end else if (bus.req1) begin
               state_d = OWN1;
            end
         end
         OWN0: begin
            if (!bus.req0) begin
               state_d = IDLE;
               last_d  = 1'b0;
            end
         end
         OWN1: begin
            if (!bus.req1) begin
               state_d = IDLE;
               last_d  = 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Pixel acceptance and write-port next state
   // ------------------------------------------------------------------
   always_comb begin
      accept     = 1'b0;
      sel_x      = bus.x0;
      sel_y      = bus.y0;
      sel_colour = bus.colour0;
      if (state_q == OWN0) begin
         accept = bus.plot0;
      end else if (state_q == OWN1) begin
         accept     = bus.plot1;
         sel_x      = bus.x1;
         sel_y      = bus.y1;
         sel_colour = bus.colour1;
      end

      on_screen = (sel_x < X_LIMIT) && (sel_y < Y_LIMIT);

      // Coordinates and colour hold their last written value between pixels.
      vga_plot_d   = accept && on_screen;
      vga_x_d      = vga_x_q;
      vga_y_d      = vga_y_q;
      vga_colour_d = vga_colour_q;
      pix_count_d  = pix_count_q;
      clip_count_d = clip_count_q;

      if (vga_plot_d) begin
         vga_x_d      = sel_x;
         vga_y_d      = sel_y;
         vga_colour_d = sel_colour;
         pix_count_d  = sat_inc_pix(pix_count_q);
      end

      if (accept && !on_screen) begin
         clip_count_d = sat_inc_clip(clip_count_q);
      end
   end

   // ------------------------------------------------------------------
   // Registers. Reset clears every output, so a pixel presented in a
   // reset cycle is dropped and never reaches the VGA port.
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         last_q       <= 1'b1;
         gnt0_q       <= 1'b0;
         gnt1_q       <= 1'b0;
         vga_x_q      <= '0;
         vga_y_q      <= '0;
         vga_colour_q <= '0;
         vga_plot_q   <= 1'b0;
         pix_count_q  <= '0;
         clip_count_q <= '0;
      end else begin
         state_q      <= state_d;
         last_q       <= last_d;
         // Grants are registered copies of the next state so they change
         // on the same edge as the state register.
         gnt0_q       <= (state_d == OWN0);
         gnt1_q       <= (state_d == OWN1);
         vga_x_q      <= vga_x_d;
         vga_y_q      <= vga_y_d;
         vga_colour_q <= vga_colour_d;
         vga_plot_q   <= vga_plot_d;
         pix_count_q  <= pix_count_d;
         clip_count_q <= clip_count_d;
      end
   end

   assign bus.gnt0       = gnt0_q;
   assign bus.gnt1       = gnt1_q;
   assign bus.vga_x      = vga_x_q;
   assign bus.vga_y      = vga_y_q;
   assign bus.vga_colour = vga_colour_q;
   assign bus.vga_plot   = vga_plot_q;
   assign bus.pix_count  = pix_count_q;
   assign bus.clip_count = clip_count_q;

endmodule

// File: tb/tb_plot_arbiter.sv
// -----------------------------------------------------------------------------
// tb_plot_arbiter
// Directed bench for plot_arbiter. Inputs change 1 time unit after a rising
// edge and outputs are sampled at the same point, i.e. they show the result
// of the edge just taken.
// -----------------------------------------------------------------------------
module tb_plot_arbiter;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   plot_arbiter_if bus ();

   plot_arbiter dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.req0 = 1'b0; bus.x0 = '0; bus.y0 = '0; bus.colour0 = '0; bus.plot0 = 1'b0;
      bus.req1 = 1'b0; bus.x1 = '0; bus.y1 = '0; bus.colour1 = '0; bus.plot1 = 1'b0;
   endtask

   initial begin
      int pulses;
      int pix_errs;
      int exp_g0;
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      idle_inputs();

      // Reset state
      step();
      step();
      chk("rst_gnt0", bus.gnt0, 0);
      chk("rst_gnt1", bus.gnt1, 0);
      chk("rst_plot", bus.vga_plot, 0);
      chk("rst_vga_x", bus.vga_x, 0);
      chk("rst_pix", bus.pix_count, 0);
      chk("rst_clip", bus.clip_count, 0);

      // First tie after reset goes to requester 0
      rst = 1'b0;
      bus.req0 = 1'b1;
      bus.req1 = 1'b1;
      step();
      chk("tie_gnt0", bus.gnt0, 1);
      chk("tie_gnt1", bus.gnt1, 0);

      // Requester 1 plots while not granted: ignored
      bus.plot1 = 1'b1; bus.x1 = 8'd5; bus.y1 = 7'd5; bus.colour1 = 3'd2;
      step();
      chk("ungr_plot_a", bus.vga_plot, 0);
      chk("ungr_gnt1", bus.gnt1, 0);
      step();
      chk("ungr_plot_b", bus.vga_plot, 0);
      chk("ungr_pix", bus.pix_count, 0);
      chk("hold_gnt0", bus.gnt0, 1);

      // Drop req0: one idle cycle, then requester 1
      bus.req0 = 1'b0;
      bus.plot1 = 1'b0;
      step();
      chk("gap_gnt0", bus.gnt0, 0);
      chk("gap_gnt1", bus.gnt1, 0);
      step();
      chk("hand_gnt1", bus.gnt1, 1);

      // Requester 1: on-screen corner then off-screen pixel
      bus.plot1 = 1'b1; bus.x1 = 8'd159; bus.y1 = 7'd119; bus.colour1 = 3'b101;
      step();
      chk("corner_plot", bus.vga_plot, 1);
      chk("corner_x", bus.vga_x, 159);
      chk("corner_y", bus.vga_y, 119);
      chk("corner_col", bus.vga_colour, 5);
      chk("corner_pix", bus.pix_count, 1);
      bus.x1 = 8'd160; bus.y1 = 7'd0; bus.colour1 = 3'b111;
      step();
      chk("clipx_plot", bus.vga_plot, 0);
      chk("clipx_clip", bus.clip_count, 1);
      chk("clipx_hold_x", bus.vga_x, 159);
      chk("clipx_hold_col", bus.vga_colour, 5);
      chk("clipx_pix", bus.pix_count, 1);
      bus.x1 = 8'd0; bus.y1 = 7'd120;
      step();
      chk("clipy_plot", bus.vga_plot, 0);
      chk("clipy_clip", bus.clip_count, 2);
      bus.plot1 = 1'b0;
      step();
      chk("noplot", bus.vga_plot, 0);

      // Reset mid-burst of requester 1 with a pixel presented
      bus.plot1 = 1'b1; bus.x1 = 8'd10; bus.y1 = 7'd10; bus.colour1 = 3'd1;
      rst = 1'b1;
      step();
      chk("mrst_gnt1", bus.gnt1, 0);
      chk("mrst_plot", bus.vga_plot, 0);
      chk("mrst_pix", bus.pix_count, 0);
      chk("mrst_clip", bus.clip_count, 0);
      chk("mrst_x", bus.vga_x, 0);
      rst = 1'b0;
      bus.plot1 = 1'b0;
      bus.req0 = 1'b1;
      step();
      chk("mrst_tie_gnt0", bus.gnt0, 1);
      chk("mrst_tie_gnt1", bus.gnt1, 0);

      // Pixel in the same cycle req0 falls is still accepted
      bus.req0 = 1'b0; bus.plot0 = 1'b1; bus.x0 = 8'd1; bus.y0 = 7'd2; bus.colour0 = 3'd3;
      step();
      chk("fall_plot", bus.vga_plot, 1);
      chk("fall_x", bus.vga_x, 1);
      chk("fall_y", bus.vga_y, 2);
      chk("fall_col", bus.vga_colour, 3);
      chk("fall_gnt0", bus.gnt0, 0);
      chk("fall_pix", bus.pix_count, 1);
      bus.plot0 = 1'b0;
      bus.req1 = 1'b0;
      step();
      chk("fall_idle_g1", bus.gnt1, 0);

      // Alternating ties from a fresh reset: 0,1,0,1
      rst = 1'b1;
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         exp_g0 = (i % 2 == 0) ? 1 : 0;
         bus.req0 = 1'b1;
         bus.req1 = 1'b1;
         step();
         chk($sformatf("rr%0d_gnt0", i), bus.gnt0, exp_g0);
         chk($sformatf("rr%0d_gnt1", i), bus.gnt1, 1 - exp_g0);
         step();
         chk($sformatf("rr%0d_hold0", i), bus.gnt0, exp_g0);
         bus.req0 = 1'b0;
         bus.req1 = 1'b0;
         step();
         chk($sformatf("rr%0d_rel", i), {bus.gnt0, bus.gnt1}, 0);
      end

      // Full-screen burst from requester 0
      bus.req0 = 1'b1;
      step();
      chk("burst_gnt0", bus.gnt0, 1);
      pulses = 0;
      pix_errs = 0;
      bus.plot0 = 1'b1;
      for (int y = 0; y < 120; y++) begin
         for (int x = 0; x < 160; x++) begin
            bus.x0 = 8'(x);
            bus.y0 = 7'(y);
            bus.colour0 = 3'((x + y) % 8);
            step();
            if (bus.vga_plot === 1'b1) pulses++;
            if (bus.vga_plot !== 1'b1 || bus.vga_x !== 8'(x) || bus.vga_y !== 7'(y)
                || bus.vga_colour !== 3'((x + y) % 8)) pix_errs++;
         end
      end
      chk("burst_pix_errs", pix_errs, 0);
      chk("burst_pulses", pulses, 19200);
      chk("burst_pix", bus.pix_count, 19200);
      bus.plot0 = 1'b0;
      step();
      chk("burst_end_plot", bus.vga_plot, 0);
      chk("burst_end_pix", bus.pix_count, 19200);

      // clip_count saturation with off-screen pixels
      bus.plot0 = 1'b1; bus.x0 = 8'd200; bus.y0 = 7'd0;
      for (int i = 0; i < 300; i++) step();
      chk("clipsat", bus.clip_count, 255);
      chk("clipsat_hold_x", bus.vga_x, 159);
      chk("clipsat_pix", bus.pix_count, 19200);

      // pix_count saturation
      bus.x0 = 8'd7; bus.y0 = 7'd7;
      for (int i = 0; i < 13600; i++) step();
      chk("pixsat", bus.pix_count, 32767);
      chk("pixsat_plot", bus.vga_plot, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
